// File: rtl/uio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uio_bus_arbiter
// Description : Round-robin owner arbiter for the shared 8-bit uio pad bus,
//               with a hold limit per tenure and a tristate gap between owners.
// Revision    : 1.0 - initial release
// ============================================================================
module uio_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int MAX_HOLD   = 16,
    parameter int TURNAROUND = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [8*NUM_REQ-1:0] req_oe,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [2:0]           owner,
    output logic                 busy,
    output logic [7:0]           uio_out,
    output logic [7:0]           uio_oe
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_GRANT  = 2'd1;
    localparam logic [1:0] c_ST_TURN   = 2'd2;
    localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [1:0] c_TURN_LAST = 2'(TURNAROUND - 1);
    localparam logic [3:0] c_NUM_REQ   = 4'(NUM_REQ);

    logic [1:0]         r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt, w_gnt_win;
    logic [2:0]         r_owner, w_owner_nxt;
    logic [2:0]         r_last, w_last_nxt;
    logic [7:0]         r_hold_cnt, w_hold_nxt;
    logic [1:0]         r_turn_cnt, w_turn_nxt;

    logic [7:0]  w_req8;
    logic [63:0] w_data64;
    logic [63:0] w_oe64;
    logic        w_found;
    logic [2:0]  w_win;
    logic [3:0]  w_cand;

    // Widen to the 8-requester maximum so owner/candidate indices are full width.
    assign w_req8   = 8'(req);
    assign w_data64 = 64'(req_data);
    assign w_oe64   = 64'(req_oe);

    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        w_cand  = 4'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_last} + 4'(k);
            if (w_cand >= c_NUM_REQ) begin
                w_cand = w_cand - c_NUM_REQ;
            end
            if (!w_found && w_req8[w_cand[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[2:0];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_gnt_win[i] = (w_win == 3'(i));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold_cnt;
        w_turn_nxt  = r_turn_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (ena && w_found) begin
                    w_state_nxt = c_ST_GRANT;
                    w_gnt_nxt   = w_gnt_win;
                    w_owner_nxt = w_win;
                    w_last_nxt  = w_win;
                    w_hold_nxt  = 8'd0;
                end
            end
            c_ST_GRANT: begin
                w_hold_nxt = r_hold_cnt + 8'd1;
                if (!w_req8[r_owner] || (r_hold_cnt == c_HOLD_LAST) || !ena) begin
                    w_state_nxt = c_ST_TURN;
                    w_gnt_nxt   = '0;
                    w_turn_nxt  = 2'd0;
                end
            end
            c_ST_TURN: begin
                if (r_turn_cnt == c_TURN_LAST) begin
                    // last still names the revoked owner, so it ranks lowest here
                    if (ena && w_found) begin
                        w_state_nxt = c_ST_GRANT;
                        w_gnt_nxt   = w_gnt_win;
                        w_owner_nxt = w_win;
                        w_last_nxt  = w_win;
                        w_hold_nxt  = 8'd0;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end else begin
                    w_turn_nxt = r_turn_cnt + 2'd1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_gnt      <= '0;
            r_owner    <= 3'd0;
            r_last     <= 3'(NUM_REQ - 1);
            r_hold_cnt <= 8'd0;
            r_turn_cnt <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_owner    <= w_owner_nxt;
            r_last     <= w_last_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_turn_cnt <= w_turn_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign owner   = r_owner;
    assign busy    = (r_state == c_ST_GRANT);
    assign uio_out = busy ? w_data64[{r_owner, 3'b000} +: 8] : 8'h00;
    assign uio_oe  = busy ? w_oe64[{r_owner, 3'b000} +: 8]   : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_uio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uio_bus_arbiter
// Description : Directed and randomized checks of uio_bus_arbiter against a
//               tenure-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uio_bus_arbiter;

    localparam int NR = 4;
    localparam int MH = 4;
    localparam int TA = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena = 1'b0;
    logic [NR-1:0] req = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [8*NR-1:0] req_oe = '0;
    logic [NR-1:0] gnt;
    logic [2:0]    owner;
    logic          busy;
    logic [7:0]    uio_out;
    logic [7:0]    uio_oe;

    int total = 0;
    int bad   = 0;

    uio_bus_arbiter #(.NUM_REQ(NR), .MAX_HOLD(MH), .TURNAROUND(TA)) dut (
        .clk(clk), .rst(rst), .ena(ena), .req(req),
        .req_data(req_data), .req_oe(req_oe),
        .gnt(gnt), .owner(owner), .busy(busy),
        .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    // Reference model: tracks who owns the bus, how long they have held it
    // and how many gap cycles remain, using modulo round-robin search.
    bit m_busy;
    int m_owner, m_last, m_held, m_gap, m_win;

    function automatic int rr_pick(input logic [NR-1:0] r, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (((r >> ((last + k) % NR)) & NR'(1)) != '0) return (last + k) % NR;
        end
        return -1;
    endfunction

    always_comb m_win = rr_pick(req, m_last);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_owner <= 0;
            m_last  <= NR - 1;
            m_held  <= 0;
            m_gap   <= 0;
        end else if (m_busy) begin
            if (((req >> m_owner) & NR'(1)) == '0 || m_held + 1 >= MH || !ena) begin
                m_busy <= 1'b0;
                m_gap  <= TA;
            end else begin
                m_held <= m_held + 1;
            end
        end else if (m_gap > 1) begin
            m_gap <= m_gap - 1;
        end else begin
            m_gap <= 0;
            if (ena && m_win >= 0) begin
                m_busy  <= 1'b1;
                m_owner <= m_win;
                m_last  <= m_win;
                m_held  <= 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        ena = 1'b0;
        req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ena = 1'b1;
        req = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (gnt !== 4'b0000 || uio_oe !== 8'h00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: gnt=%b uio_oe=%h busy=%b, want 0000/00/0", gnt, uio_oe, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL reset_first_grant: gnt=%b want 0001", gnt);
        end
    endtask

    task automatic test_single;
        do_reset();
        ena = 1'b1;
        req_data = 32'h1122_3344;
        req_oe   = 32'h0F0F_0F0F;
        req_data[23:16] = 8'hA5;
        req_oe[23:16]   = 8'hFF;
        req = 4'b0100;
        tick();
        total++;
        if (gnt !== 4'b0100 || owner !== 3'd2 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_grant: gnt=%b owner=%0d busy=%b want 0100/2/1", gnt, owner, busy);
        end
        total++;
        if (uio_out !== 8'hA5 || uio_oe !== 8'hFF) begin
            bad++;
            $display("FAIL single_pads: out=%h oe=%h want A5/FF", uio_out, uio_oe);
        end
        req_data[23:16] = 8'h3C;
        #1;
        total++;
        if (uio_out !== 8'h3C) begin
            bad++;
            $display("FAIL single_comb_data: out=%h want 3C", uio_out);
        end
        tick();
        req = 4'b0000;
        for (int c = 0; c < TA + 1; c++) begin
            tick();
            total++;
            if (uio_oe !== 8'h00 || gnt !== 4'b0000 || busy !== 1'b0) begin
                bad++;
                $display("FAIL single_release c%0d: oe=%h gnt=%b busy=%b want 00/0000/0", c, uio_oe, gnt, busy);
            end
        end
    endtask

    task automatic test_round_robin;
        logic [NR-1:0] exp;
        do_reset();
        ena = 1'b1;
        req = 4'b1111;
        for (int c = 0; c < 5 * (MH + TA); c++) begin
            tick();
            exp = ((c % (MH + TA)) < MH) ? NR'(1) << ((c / (MH + TA)) % NR) : '0;
            total++;
            if (gnt !== exp) begin
                bad++;
                $display("FAIL round_robin c%0d: gnt=%b want %b", c, gnt, exp);
            end
        end
    endtask

    task automatic test_fairness;
        logic [NR-1:0] exp_seq [6];
        exp_seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000};
        do_reset();
        ena = 1'b1;
        req = 4'b0010;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 1) req = 4'b1010;
            total++;
            if (gnt !== exp_seq[c]) begin
                bad++;
                $display("FAIL fairness c%0d: gnt=%b want %b", c, gnt, exp_seq[c]);
            end
        end
    endtask

    task automatic test_ena_drop;
        do_reset();
        ena = 1'b1;
        req = 4'b0001;
        req_oe = 32'hFFFF_FFFF;
        tick();
        tick();
        ena = 1'b0;
        tick();
        total++;
        if (gnt !== 4'b0000 || uio_oe !== 8'h00) begin
            bad++;
            $display("FAIL ena_drop: gnt=%b oe=%h want 0000/00", gnt, uio_oe);
        end
        for (int c = 0; c < 6; c++) begin
            req = NR'($urandom_range(1, 15));
            tick();
            total++;
            if (gnt !== 4'b0000 || busy !== 1'b0) begin
                bad++;
                $display("FAIL ena_low_hold c%0d: gnt=%b busy=%b want 0000/0", c, gnt, busy);
            end
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        ena = 1'b1;
        req = 4'b0100;
        req_oe = 32'hFFFF_FFFF;
        tick();
        total++;
        if (gnt !== 4'b0100) begin
            bad++;
            $display("FAIL async_pre: gnt=%b want 0100", gnt);
        end
        #2;
        rst = 1'b1;
        req = 4'b1111;
        #1;
        total++;
        if (gnt !== 4'b0000 || uio_oe !== 8'h00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: gnt=%b oe=%h busy=%b want 0000/00/0", gnt, uio_oe, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL async_after: gnt=%b want 0001", gnt);
        end
    endtask

    task automatic test_random;
        logic [NR-1:0] exp_gnt;
        logic [7:0]    exp_out, exp_oe;
        do_reset();
        ena = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = NR'($urandom);
            ena      = ($urandom_range(0, 15) != 0);
            req_data = $urandom;
            req_oe   = $urandom;
            tick();
            exp_gnt = m_busy ? (NR'(1) << m_owner) : '0;
            exp_out = m_busy ? 8'(req_data >> (8 * m_owner)) : 8'h00;
            exp_oe  = m_busy ? 8'(req_oe >> (8 * m_owner)) : 8'h00;
            total++;
            if (gnt !== exp_gnt || busy !== m_busy) begin
                bad++;
                $display("FAIL rand_gnt c%0d: gnt=%b busy=%b want %b/%b", c, gnt, busy, exp_gnt, m_busy);
            end
            total++;
            if (uio_out !== exp_out || uio_oe !== exp_oe) begin
                bad++;
                $display("FAIL rand_pads c%0d: out=%h oe=%h want %h/%h", c, uio_out, uio_oe, exp_out, exp_oe);
            end
            if (m_busy) begin
                total++;
                if (owner !== 3'(m_owner)) begin
                    bad++;
                    $display("FAIL rand_owner c%0d: owner=%0d want %0d", c, owner, m_owner);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_ena_drop();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uio_bus_arbiter.md
# uio_bus_arbiter

Round-robin arbiter that shares the 8-bit bidirectional `uio` pad bus of the `tt_um_pchri03_top` design between up to `NUM_REQ` internal requesters. It grants one owner at a time, routes that owner's data and output-enable to the pads, and caps each tenure at `MAX_HOLD` cycles. It inserts a `TURNAROUND`-cycle tristate gap between owners so the pads never see overlapping drivers. It sits between the internal engines and the top-level `uio_out`/`uio_oe` pins.

## Interface

- `NUM_REQ`, 4: number of requesters, range 2..8.
- `MAX_HOLD`, 16: maximum consecutive granted cycles per tenure, range 1..255.
- `TURNAROUND`, 1: tristate cycles between tenures, range 1..3.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ena`  in  1  design enable; when low, no new grants are issued and the current grant is revoked.
- `req`  in  NUM_REQ  per-requester bus request, level-sensitive.
- `req_data`  in  8*NUM_REQ  per-requester pad data; requester i uses bits [8i+7:8i].
- `req_oe`  in  8*NUM_REQ  per-requester pad output-enable, packed the same way.
- `gnt`  out  NUM_REQ  one-hot grant, registered.
- `owner`  out  3  index of the current grant holder; valid only while `busy`=1.
- `busy`  out  1  high in GRANT.
- `uio_out`  out  8  pad data: `req_data` of the owner in GRANT, 0 otherwise.
- `uio_oe`  out  8  pad enable: `req_oe` of the owner in GRANT, 0 otherwise.

## Operation

- The block has three states: IDLE, GRANT and TURN.
- Round-robin pointer `last` holds the most recent owner.
  - The search for the next owner starts at `last+1` and wraps modulo NUM_REQ.
  - Reset sets `last` = NUM_REQ-1, so requester 0 has first priority.
- IDLE:
  - If `ena`=1 and any `req` bit is set, pick the winner, set `gnt`, `owner` and `last`, clear `hold_cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - `hold_cnt` increments every cycle.
  - Leave for TURN, clearing `gnt`, when any of these is true: `req[owner]`=0, `hold_cnt`=MAX_HOLD-1, or `ena`=0.
  - Otherwise stay in GRANT.
- TURN:
  - Lasts exactly TURNAROUND cycles, counted by `turn_cnt`. `gnt`=0 and `uio_oe`=0 throughout.
  - On exit, if `ena`=1 and any `req` is set, go to GRANT with the next round-robin winner. Otherwise go to IDLE.
- A revoked owner whose `req` is still high has lowest priority for the next grant, because `last` equals that owner.
- `uio_out`/`uio_oe` are a combinational mux of `req_data`/`req_oe` selected by the registered `owner`, gated by the GRANT state.
- Requests arriving or dropping in TURN never shorten the gap.
- Reset values: state IDLE, `gnt`=0, `owner`=0, `busy`=0, `uio_out`=0, `uio_oe`=0, `hold_cnt`=0, `turn_cnt`=0.
- Asserting `rst` mid-tenure clears `gnt` and `uio_oe` immediately, without waiting for a clock edge.

## Timing

- Grant latency: `req` first high at edge N in IDLE, then `gnt` high after edge N, which is 1 cycle.
- Pad data follows `req_data` of the owner in the same cycle (combinational path) while in GRANT.
- Release: `req[owner]` sampled low at edge N, then `gnt`=0 and `uio_oe`=0 after edge N.
- The next grant is visible after edge N+TURNAROUND.
- Maximum tenure is exactly MAX_HOLD cycles of `gnt` high.
- Minimum gap between two tenures is TURNAROUND cycles with `uio_oe`=0.
- Any requester with `req` held high is granted within (NUM_REQ-1)×(MAX_HOLD+TURNAROUND)+1 cycles while `ena`=1.
- Simultaneous events in GRANT:
  - Release and hold expiry on the same edge produce a single TURN entry.
  - `ena` falling on the same edge as a grant decision in IDLE issues no grant.

## Test plan

- **Reset:** hold `rst`=1 with `req`=4'b1111. Expect `gnt`=0, `uio_oe`=8'h00 and `busy`=0. Release `rst` with `ena`=1; expect `gnt`=4'b0001 one cycle later.
- **Single request:**
  - Raise only `req[2]` with `req_data[2]`=8'hA5 and `req_oe[2]`=8'hFF.
  - Expect `gnt`=4'b0100 after 1 cycle, then `uio_out`=8'hA5 and `uio_oe`=8'hFF.
  - Drop `req[2]`; expect `uio_oe`=8'h00 for TURNAROUND cycles, then IDLE.
- **Round-robin:**
  - Hold `req`=4'b1111 continuously with MAX_HOLD=4 and TURNAROUND=1.
  - Expect grant order 0,1,2,3,0.
  - Expect each tenure to last exactly 4 cycles, separated by exactly 1 cycle with `gnt`=0.
- **Preemption fairness:**
  - `req[1]` is held; `req[3]` rises mid-tenure of requester 1.
  - After requester 1 has held for MAX_HOLD cycles, expect `gnt`=4'b1000 next, not requester 1 again.
- **Enable drop:** drop `ena` during the GRANT of requester 0. Expect `gnt`=0 and `uio_oe`=0 after the next edge, and no further grants while `ena`=0.
- **Asynchronous reset mid-tenure:**
  - Assert `rst` between clock edges while requester 2 is granted.
  - Expect `gnt`, `uio_oe` and `busy` to drop before the next edge.
  - After release, expect requester 0 to be the first grant.
